// File: rtl/shift_seq_ctrl.sv
// Load/shift sequencer: accepts a word, loads it into an external shift register,
// shifts it out while capturing the serial output. Optional macro: SHIFT_SEQ_LOOPCHK_EN.
module shift_seq_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_word,
  input  logic             sin,
  output logic             load,
  output logic             di,
  output logic [WIDTH-1:0] d,
  input  logic             do_in,
  output logic [WIDTH-1:0] rx_word,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid)      state_d = LOAD;
      LOAD:                          state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (rx_ready)         state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // cnt saturates on the last shift edge so it never wraps for power-of-two widths
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            tx_q  <= tx_word;
            rx_q  <= '0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          rx_q <= {rx_q[WIDTH-2:0], do_in};
          if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign load        = (state_q == LOAD);
  assign di          = (state_q == SHIFT) & sin;
  assign d           = tx_q;
  assign rx_word     = rx_q;
  assign rx_valid    = (state_q == DONE);
  assign busy        = (state_q != IDLE);

`ifdef SHIFT_SEQ_LOOPCHK_EN
  // compare against the value rx takes on the final shift edge, held through DONE
  logic err_q;
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      err_q <= 1'b0;
    end else if (state_q == SHIFT && state_d == DONE) begin
      err_q <= ({rx_q[WIDTH-2:0], do_in} != tx_q);
    end else if (state_q == DONE && state_d != DONE) begin
      err_q <= 1'b0;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl (WIDTH=3) with a behavioural shift register on
// load/di/d/do_in; expected words are pushed at accept and popped on the rx handshake.
module tb_shift_seq_ctrl;

  localparam int W = 3;

`ifdef SHIFT_SEQ_LOOPCHK_EN
  localparam logic MISMATCH_ERR = 1'b1;
`else
  localparam logic MISMATCH_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clrn;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] tx_word;
  logic         sin;
  logic         load;
  logic         di;
  logic [W-1:0] d;
  logic         do_in;
  logic [W-1:0] rx_word;
  logic         rx_valid;
  logic         rx_ready;
  logic         busy;
  logic         err;

  logic         force_zero = 1'b0;
  logic [W-1:0] sh_q = '0;

  typedef struct {
    logic [W-1:0] w;
    logic         e;
  } exp_t;
  exp_t sb_q[$];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .clrn(clrn), .start_valid(start_valid), .start_ready(start_ready),
    .tx_word(tx_word), .sin(sin), .load(load), .di(di), .d(d), .do_in(do_in),
    .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy), .err(err)
  );

  // behavioural shifter following the load/shift contract
  always @(posedge clk) begin
    if (load) sh_q <= d;
    else      sh_q <= {sh_q[W-2:0], di};
  end
  assign do_in = force_zero ? 1'b0 : sh_q[W-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pop one expectation per completed rx handshake
  always @(negedge clk) begin
    exp_t e;
    if (clrn && rx_valid && rx_ready) begin
      check("sb_has_entry", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rx_word", rx_word, e.w);
        check("rx_err", err, e.e);
      end
    end
  end

  // Caller is at posedge+#1 in IDLE; returns in the first DONE cycle.
  task automatic run_word(input logic [W-1:0] w, input logic [W-1:0] exp_rx,
                          input logic exp_e, input logic tog, output int lat);
    int load_extra;
    start_valid = 1'b1;
    tx_word     = w;
    @(posedge clk);
    sb_q.push_back('{w: exp_rx, e: exp_e});
    #1;
    start_valid = 1'b0;
    tx_word     = '0;
    check("load_in_load", load, 1);
    check("d_in_load", d, w);
    check("busy_in_load", busy, 1);
    if (tog) check("di_in_load", di, 0);
    lat        = 0;
    load_extra = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (tog) begin
        sin = ~sin;
        #1;
        check("di_fwd", di, (i <= W) ? sin : 1'b0);
      end
      if (load) load_extra++;
      if (rx_valid) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, W + 1);
    check("load_one_cycle", load_extra, 0);
  endtask

  initial begin
    int lat;
    clrn        = 1'b0;
    start_valid = 1'b0;
    tx_word     = '0;
    sin         = 1'b0;
    rx_ready    = 1'b0;
    #3;
    check("rst_start_ready", start_ready, 1);
    check("rst_load", load, 0);
    check("rst_di", di, 0);
    check("rst_d", d, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);

    // no handshake while held in reset
    start_valid = 1'b1;
    tx_word     = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_accept", busy, 0);
    start_valid = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // loopback 010
    rx_ready = 1'b1;
    run_word(3'b010, 3'b010, 1'b0, 1'b0, lat);
    @(posedge clk);
    #1;
    check("lb_idle_busy", busy, 0);
    check("lb_idle_ready", start_ready, 1);

    // backpressure on 101 with ignored start_valid in DONE
    rx_ready = 1'b0;
    run_word(3'b101, 3'b101, 1'b0, 1'b0, lat);
    start_valid = 1'b1;
    tx_word     = 3'b011;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {rx_valid, rx_word, start_ready, busy}, {1'b1, 3'b101, 1'b0, 1'b1});
      check("bp_d_kept", d, 3'b101);
      @(posedge clk);
      #1;
    end
    start_valid = 1'b0;
    rx_ready    = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {busy, rx_valid}, 2'b00);

    // serial forwarding on 110
    run_word(3'b110, 3'b110, 1'b0, 1'b1, lat);
    @(posedge clk);
    #1;
    check("sf_idle", busy, 0);
    sin = 1'b0;

    // reset in the 2nd SHIFT cycle
    sin         = 1'b1;
    start_valid = 1'b1;
    tx_word     = 3'b011;
    @(posedge clk);
    sb_q.push_back('{w: 3'b011, e: 1'b0});
    #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    check("mr_outputs", {load, di, d, rx_word, rx_valid, busy, err, start_ready},
          {1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1});
    sb_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("mr_no_valid", rx_valid, 0);
    end
    clrn = 1'b1;
    sin  = 1'b0;
    @(posedge clk);
    #1;
    run_word(3'b011, 3'b011, 1'b0, 1'b0, lat);
    @(posedge clk);
    #1;
    check("mr_recover_idle", busy, 0);

    // forced mismatch on 111
    force_zero = 1'b1;
    rx_ready   = 1'b0;
    run_word(3'b111, 3'b000, MISMATCH_ERR, 1'b0, lat);
    for (int i = 0; i < 2; i++) begin
      check("mm_err_held", err, MISMATCH_ERR);
      check("mm_rx_word", rx_word, 3'b000);
      @(posedge clk);
      #1;
    end
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("mm_err_clear", {err, busy}, 2'b00);
    force_zero = 1'b0;

    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
